// File: rtl/byte_serial_adder_pkg.sv
// Shared types and constants for the byte-serial adder.
package byte_serial_adder_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_serial_adder_adder_8bit.sv
// adder_8bit: combinational 8-bit ripple-carry adder; also exposes the carry
// into the MSB so the caller can derive two's-complement overflow.
module adder_8bit
  import byte_serial_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s_c,
  output logic              msb_carry_c,
  output logic              cout_c
);

  logic [BYTE_W:0] c;

  always_comb begin
    c    = '0;
    s_c  = '0;
    c[0] = cin;
    for (int i = 0; i < BYTE_W; i++) begin
      s_c[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign msb_carry_c = c[BYTE_W-1];
  assign cout_c      = c[BYTE_W];

endmodule

// File: rtl/byte_serial_adder.sv
// Byte-serial adder: one byte per cycle through a single 8-bit ripple adder.
// Define OVERFLOW_FLAG_EN to add the two's-complement overflow output.
module byte_serial_adder
  import byte_serial_adder_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] x,
  input  logic [BYTE_W*NBYTES-1:0] y,
  input  logic                     carry_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     final_carry_out,
`ifdef OVERFLOW_FLAG_EN
  output logic                     overflow,
`endif
  output logic                     busy
);

  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q;
  logic                            carry_q;
  logic [NBYTES-1:0][BYTE_W-1:0]   x_q, y_q, sum_q;
  logic                            fco_q;
  logic                            load, step, last;
  logic [BYTE_W-1:0]               add_s;
  logic                            add_msb_carry, add_cout;

  assign last = (idx_q == IDX_W'(NBYTES - 1));

  adder_8bit u_adder (
    .a           (x_q[idx_q]),
    .b           (y_q[idx_q]),
    .cin         (carry_q),
    .s_c         (add_s),
    .msb_carry_c (add_msb_carry),
    .cout_c      (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and Moore handshake outputs decoded from the state register.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and per-byte accumulation into the sum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      fco_q   <= 1'b0;
    end else if (load) begin
      x_q     <= x;
      y_q     <= y;
      carry_q <= carry_in;
      idx_q   <= '0;
    end else if (step) begin
      sum_q[idx_q] <= add_s;
      carry_q      <= add_cout;
      idx_q        <= idx_q + IDX_W'(1);
      if (last) fco_q <= add_cout;
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ovf_q <= 1'b0;
    else if (step && last) ovf_q <= add_msb_carry ^ add_cout;
  end

  assign overflow = ovf_q;
`else
  logic unused_msb_carry;
  assign unused_msb_carry = add_msb_carry;
`endif

  assign sum             = sum_q;
  assign final_carry_out = fco_q;

endmodule

// File: doc/byte_serial_adder.md
BYTE_SERIAL_ADDER -- requirements
Module: byte_serial_adder

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands and carry-in are present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have ports x and y, input, 8*NBYTES bits each: the unsigned operands.
REQ-007 The block SHALL have port carry_in, input, 1 bit: carry into byte 0.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is held stable.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port sum, output, 8*NBYTES bits: the registered sum.
REQ-011 The block SHALL have port final_carry_out, output, 1 bit: carry out of the top byte.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN state.

Function
REQ-013 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL be high only in IDLE; out_valid SHALL be high only in DONE; busy SHALL be high only in RUN.
REQ-015 IDLE with in_valid=1 SHALL latch x, y and carry_in, clear the byte index to 0, and go to RUN; in_valid=0 SHALL keep IDLE.
REQ-016 Each RUN cycle SHALL add byte[idx] of x and y plus the carry register through one combinational 8-bit ripple adder, and write the result to byte[idx] of the sum register.
REQ-017 Each RUN cycle SHALL load the adder carry-out into the carry register and increment idx.
REQ-018 When idx=NBYTES-1, RUN SHALL go to DONE; final_carry_out SHALL equal the carry out of that last byte.
REQ-019 Latency SHALL be exactly NBYTES cycles: out_valid rises on the NBYTES-th rising edge after the accepting edge.
REQ-020 DONE SHALL hold sum and final_carry_out stable until out_ready=1, then go to IDLE on that edge.
REQ-021 No new operands SHALL be accepted in the cycle of the output handshake; the next acceptance is at the earliest one cycle later.
REQ-022 x, y, carry_in and in_valid SHALL be ignored outside IDLE; changing them during RUN SHALL NOT alter the result.
REQ-023 The arithmetic SHALL be modulo 2^(8*NBYTES), with the wrap-around carry reported only on final_carry_out.
REQ-024 sum and final_carry_out SHALL retain the last result in IDLE until the next result overwrites them.

Reset
REQ-025 Asserting rst SHALL immediately force the state to IDLE.
REQ-026 Asserting rst SHALL clear idx, the carry register, the operand registers, sum and final_carry_out to 0.
REQ-027 During reset, out_valid and busy SHALL be 0 and in_ready SHALL be 1.
REQ-028 Reset asserted during RUN or DONE SHALL discard the operation with no output handshake.

Configuration
REQ-029 With OVERFLOW_FLAG_EN defined, the block SHALL have output overflow, 1 bit, registered with sum and valid with out_valid.
REQ-030 overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB of the top byte (two's-complement overflow) and SHALL reset to 0.
REQ-031 Without OVERFLOW_FLAG_EN, the overflow port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-032 Package byte_serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the constant BYTE_W=8.
REQ-033 The per-byte adder SHALL be one instance of the existing adder_8bit sub-module, driven by the operand byte mux and the carry register.

Verification
REQ-034 NBYTES=4, x=0x12345678, y=0x11111111, cin=0 -> sum=0x23456789, carry 0; out_valid 4 cycles after acceptance.
REQ-035 x=0xFFFFFFFF, y=0x00000000, cin=1 -> sum=0x00000000, final_carry_out=1; the carry ripples through all bytes.
REQ-036 x=0x7FFFFFFF, y=0x00000001, cin=0 -> sum=0x80000000, carry 0; overflow=1 when OVERFLOW_FLAG_EN is defined.
REQ-037 out_ready held 0 for 5 cycles in DONE -> sum stable, in_ready=0 and new in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-038 rst pulsed on the 2nd RUN cycle -> same-cycle IDLE with all outputs 0; a following add of 0x1+0x1 returns 0x2.
REQ-039 x/y toggled randomly during RUN -> result equals the sum of the operands captured at acceptance.
